// File: rtl/ser_link_phy_tx_if.sv
// Flit ingress, credit return and DDR pad-side lanes of the serial link transmitter.
// The transmitter takes the slave side; the flit source and credit returner take the master side.
interface ser_link_phy_tx_if #(
  parameter int FlitWidth  = 32,
  parameter int NumLanes   = 4,
  parameter int MaxCredits = 8
);
  localparam int CntW = $clog2(MaxCredits + 1);

  logic [FlitWidth-1:0] flit_i;
  logic                 flit_valid_i;
  logic                 flit_ready_o;
  logic                 credit_i;
  logic [NumLanes-1:0]  ddr_rise_o;
  logic [NumLanes-1:0]  ddr_fall_o;
  logic                 clk_fwd_en_o;
  logic [CntW-1:0]      credits_o;
  logic                 credit_err_o;

  modport slave (
    input  flit_i, flit_valid_i, credit_i,
    output flit_ready_o, ddr_rise_o, ddr_fall_o, clk_fwd_en_o, credits_o, credit_err_o
  );

  modport master (
    output flit_i, flit_valid_i, credit_i,
    input  flit_ready_o, ddr_rise_o, ddr_fall_o, clk_fwd_en_o, credits_o, credit_err_o
  );
endinterface

// File: rtl/ser_link_phy_tx.sv
// Credit-gated flit serializer onto NumLanes DDR lanes: beat 0 leaves one cycle after accept, flits run back-to-back.
// Ready is low mid-flit and at zero credits; a credit returned while full saturates and latches credit_err_o.
module ser_link_phy_tx #(
  parameter int FlitWidth  = 32,
  parameter int NumLanes   = 4,
  parameter int MaxCredits = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  ser_link_phy_tx_if.slave link
);

  localparam int BeatW = 2 * NumLanes;
  localparam int Beats = FlitWidth / BeatW;
  localparam int KW    = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int CntW  = $clog2(MaxCredits + 1);

  localparam logic [KW-1:0]   KLast = KW'(Beats - 1);
  localparam logic [CntW-1:0] CMax  = CntW'(MaxCredits);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [KW-1:0]       r_k, w_k_nxt;
  logic [FlitWidth-1:0] r_shift, w_shift_nxt;
  logic [NumLanes-1:0] r_rise, w_rise_nxt;
  logic [NumLanes-1:0] r_fall, w_fall_nxt;
  logic                r_fwd_en, w_fwd_en_nxt;
  logic [CntW-1:0]     r_credits, w_credits_nxt;
  logic                r_err, w_err_nxt;

  logic                w_ready;
  logic                w_accept;
  logic [BeatW-1:0]    w_beat;

  // Ready looks only at registered state so the source may wait on it before raising valid.
  assign w_ready  = ((r_state == ST_IDLE) || ((r_state == ST_SEND) && (r_k == KLast)))
                    && (r_credits != '0);
  assign w_accept = link.flit_valid_i && w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_shift   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_fwd_en  <= 1'b0;
      r_credits <= CMax;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_shift   <= w_shift_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_fwd_en  <= w_fwd_en_nxt;
      r_credits <= w_credits_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // The shift register holds only the beats still to be sent; the beat being loaded
  // into the lane registers is taken straight from its source.
  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_shift_nxt  = r_shift;
    w_beat       = '0;
    w_fwd_en_nxt = 1'b0;

    if (w_accept) begin
      w_state_nxt  = ST_SEND;
      w_k_nxt      = '0;
      w_beat       = link.flit_i[BeatW-1:0];
      w_shift_nxt  = link.flit_i >> BeatW;
      w_fwd_en_nxt = 1'b1;
    end else if (r_state == ST_SEND) begin
      if (r_k == KLast) begin
        w_state_nxt = ST_IDLE;
        w_k_nxt     = '0;
        w_shift_nxt = '0;
      end else begin
        w_k_nxt      = r_k + KW'(1);
        w_beat       = r_shift[BeatW-1:0];
        w_shift_nxt  = r_shift >> BeatW;
        w_fwd_en_nxt = 1'b1;
      end
    end

    w_rise_nxt = w_beat[NumLanes-1:0];
    w_fall_nxt = w_beat[BeatW-1:NumLanes];
  end

  // Accept and credit return in the same cycle cancel; a return while full is an overflow.
  always_comb begin
    w_credits_nxt = r_credits;
    w_err_nxt     = r_err;

    if (w_accept && !link.credit_i) begin
      w_credits_nxt = r_credits - CntW'(1);
    end else if (!w_accept && link.credit_i) begin
      if (r_credits == CMax) begin
        w_err_nxt = 1'b1;
      end else begin
        w_credits_nxt = r_credits + CntW'(1);
      end
    end
  end

  assign link.flit_ready_o = w_ready;
  assign link.ddr_rise_o   = r_rise;
  assign link.ddr_fall_o   = r_fall;
  assign link.clk_fwd_en_o = r_fwd_en;
  assign link.credits_o    = r_credits;
  assign link.credit_err_o = r_err;

endmodule

// File: doc/ser_link_phy_tx.md
SER_LINK_PHY_TX -- requirements
Module: ser_link_phy_tx

Interface
REQ-001 FlitWidth, 32, payload bits per flit; SHALL be a multiple of 2*NumLanes.
REQ-002 NumLanes, 4, DDR data lanes, matching ddr0..ddr3 of the pad interface.
REQ-003 MaxCredits, 8, receiver FIFO depth in flits and the credit counter ceiling.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 flit_i  in  FlitWidth  payload to transmit.
REQ-007 flit_valid_i  in  1  payload valid.
REQ-008 flit_ready_o  out  1  payload accepted when valid and ready are both high.
REQ-009 credit_i  in  1  one-cycle pulse, one freed receiver slot.
REQ-010 ddr_rise_o  out  NumLanes  lane bits driven on the forwarded-clock rising edge, to the pad DDR cell.
REQ-011 ddr_fall_o  out  NumLanes  lane bits driven on the forwarded-clock falling edge, to the pad DDR cell.
REQ-012 clk_fwd_en_o  out  1  forwarded-clock (ddr_clk) gate; high only while a beat is on the lanes.
REQ-013 credits_o  out  $clog2(MaxCredits+1)  current credit count.
REQ-014 credit_err_o  out  1  sticky flag for credit overflow.

Function
REQ-015 Beats per flit: B = FlitWidth/(2*NumLanes), which is 4 at the default parameters.
REQ-016 FSM states:
- IDLE: no flit in flight.
- SEND: beat counter k runs 0..B-1.
REQ-017 flit_ready_o = (state==IDLE or (state==SEND and k==B-1)) and credits_o>0.
- Combinational from registered state only.
- SHALL NOT depend on flit_valid_i.
REQ-018 Accept at cycle N:
- Flit is latched into the shift register.
- FSM enters SEND with k=0.
- Beat 0 appears on the outputs at cycle N+1, since all lane outputs are registered.
REQ-019 Beat k lane mapping:
- ddr_rise_o[i] = flit[2*NumLanes*k + i].
- ddr_fall_o[i] = flit[2*NumLanes*k + NumLanes + i].
- Least-significant bits go first.
REQ-020 clk_fwd_en_o SHALL be high exactly in cycles where a beat is presented; the gated clock is the only framing.
REQ-021 When no beat is presented, ddr_rise_o, ddr_fall_o and clk_fwd_en_o SHALL be 0.
REQ-022 On the last beat (k==B-1):
- If a new flit is accepted, beat 0 of that flit follows in the next cycle with no gap.
- Otherwise the FSM returns to IDLE.
REQ-023 Credits start at MaxCredits.
- Accept only: decrement by 1.
- credit_i only: increment by 1.
- Both in the same cycle: unchanged.
REQ-024 At credits_o==0, flit_ready_o SHALL be low; an in-flight flit still completes all B beats.
REQ-025 credit_i with credits_o==MaxCredits and no simultaneous accept:
- Count saturates at MaxCredits.
- credit_err_o is set and held until reset.
REQ-026 flit_i changes after acceptance SHALL NOT affect beats already in flight.
REQ-027 The credit counter SHALL never wrap below 0 or above MaxCredits.

Reset
REQ-028 While rst_ni is low, and asynchronously on assertion, the block SHALL reach:
- state IDLE, k=0, shift register 0;
- ddr_rise_o, ddr_fall_o and clk_fwd_en_o = 0;
- credits_o = MaxCredits;
- credit_err_o = 0.
REQ-029 Reset asserted mid-flit SHALL abort the flit immediately; no residual beats after release.
REQ-030 First acceptance possible in the first clock edge after rst_ni deasserts.

Verification
REQ-031 Single flit 0x87654321 accepted at cycle N, then:
- Cycles N+1..N+4, ddr_rise_o/ddr_fall_o = 1/2, 3/4, 5/6, 7/8.
- clk_fwd_en_o high for those cycles only.
- credits_o 8->7.
REQ-032 Valid held continuously with 8 flits and no credit_i:
- 32 contiguous beat cycles.
- flit_ready_o low after the 8th acceptance.
- credits_o=0.
- Lanes idle 0 after the last beat.
REQ-033 credits_o=0 with valid high, then a single credit_i pulse:
- Ready rises in the next cycle.
- Exactly one flit is accepted.
- credits_o returns to 0.
REQ-034 Accept and credit_i in the same cycle at credits_o=5 -> credits_o stays 5.
REQ-035 credit_i pulse at credits_o=8 with no traffic -> credits_o stays 8 and credit_err_o=1 until reset.
REQ-036 rst_ni pulsed low during beat 2 of a flit:
- Outputs go to 0 asynchronously.
- credits_o=8 and credit_err_o=0.
- No further beats until a new accept.
